// File: rtl/fp_add_share_ctrl_if.sv
// Bus bundle between the FP issue logic, the shared adder and the result consumer.
interface fp_add_share_ctrl_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_res;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_id;
    logic        busy;

    // Scheduler side: takes requests and the adder sum, drives adder operands and results.
    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  add_res, res_ready,
        output req0_ready, req1_ready,
        output add_a, add_b,
        output res_valid, res_data, res_id, busy
    );

    // Environment side: requesters, shared adder and result consumer.
    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output add_res, res_ready,
        input  req0_ready, req1_ready,
        input  add_a, add_b,
        input  res_valid, res_data, res_id, busy
    );
endinterface

// File: rtl/fp_add_share_ctrl.sv
// Round-robin scheduler time-sharing one combinational FP32 adder between two requesters.
//
// state  | meaning
// IDLE   | arbitrating; the granted requester sees ready
// BUSY   | operands held on the adder, counting down the settle latency
// RESP   | sum captured, held on the result port until res_ready
module fp_add_share_ctrl #(
    parameter int ADD_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    fp_add_share_ctrl_if.slave   bus
);

    localparam int CW = (ADD_LAT < 1) ? 1 : $clog2(ADD_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   counter;
    logic            last_grant;
    logic            grant;
    logic            accept0;
    logic            accept1;
    logic            req0_ready;
    logic            req1_ready;
    logic            res_valid;

    // Round-robin grant: a lone valid requester wins, a tie goes to the one not served last.
    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant;
        end else if (bus.req1_valid) begin
            grant = 1'b1;
        end
    end

    assign accept0 = bus.req0_valid && req0_ready;
    assign accept1 = bus.req1_valid && req1_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept0 || accept1) begin
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (counter == '0) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (res_valid && bus.res_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs: ready only while arbitrating and never during reset.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state == S_IDLE && !rst) begin
            req0_ready = (grant == 1'b0);
            req1_ready = (grant == 1'b1);
        end
    end

    // Operand capture, latency countdown and result capture; operands stay put between jobs.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.add_a    <= '0;
            bus.add_b    <= '0;
            bus.res_data <= '0;
            bus.res_id   <= 1'b0;
            res_valid    <= 1'b0;
            last_grant   <= 1'b1;
            counter      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept0) begin
                        bus.add_a  <= bus.req0_a;
                        bus.add_b  <= bus.req0_b;
                        bus.res_id <= 1'b0;
                        last_grant <= 1'b0;
                        counter    <= CW'(ADD_LAT - 1);
                    end else if (accept1) begin
                        bus.add_a  <= bus.req1_a;
                        bus.add_b  <= bus.req1_b;
                        bus.res_id <= 1'b1;
                        last_grant <= 1'b1;
                        counter    <= CW'(ADD_LAT - 1);
                    end
                end
                S_BUSY: begin
                    if (counter != '0) begin
                        counter <= counter - 1'b1;
                    end else begin
                        bus.res_data <= bus.add_res;
                        res_valid    <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (res_valid && bus.res_ready) begin
                        res_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req0_ready = req0_ready;
    assign bus.req1_ready = req1_ready;
    assign bus.res_valid  = res_valid;
    assign bus.busy       = (state != S_IDLE);

endmodule

// File: tb/tb_fp_add_share_ctrl.sv
// Directed bench for fp_add_share_ctrl: one instance at ADD_LAT=2, one at ADD_LAT=1.
module tb_fp_add_share_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    fp_add_share_ctrl_if bus2 ();
    fp_add_share_ctrl_if bus1 ();

    fp_add_share_ctrl #(.ADD_LAT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
    fp_add_share_ctrl #(.ADD_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    // Stand-in adder: known sums for the test operands, a distinct pattern otherwise.
    function automatic logic [31:0] fadd_model(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        if (a == 32'h3F80_0000 && b == 32'h3F80_0000) return 32'h4000_0000;
        if (a == 32'h4040_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
        return a ^ b;
    endfunction

    assign bus2.add_res = fadd_model(bus2.add_a, bus2.add_b);
    assign bus1.add_res = fadd_model(bus1.add_a, bus1.add_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus2.req0_valid = 0; bus2.req0_a = 0; bus2.req0_b = 0;
        bus2.req1_valid = 0; bus2.req1_a = 0; bus2.req1_b = 0;
        bus2.res_ready  = 0;
        bus1.req0_valid = 0; bus1.req0_a = 0; bus1.req0_b = 0;
        bus1.req1_valid = 0; bus1.req1_a = 0; bus1.req1_b = 0;
        bus1.res_ready  = 0;

        // Reset state
        rst = 1;
        tick(); tick();
        chk("rst_res_valid", 32'(bus2.res_valid), 32'd0);
        chk("rst_res_data",  bus2.res_data, 32'd0);
        chk("rst_res_id",    32'(bus2.res_id), 32'd0);
        chk("rst_add_a",     bus2.add_a, 32'd0);
        chk("rst_add_b",     bus2.add_b, 32'd0);
        chk("rst_busy",      32'(bus2.busy), 32'd0);
        chk("rst_ready0",    32'(bus2.req0_ready), 32'd0);
        chk("rst_ready1",    32'(bus2.req1_ready), 32'd0);

        // 1: single req0 transaction
        rst = 0;
        bus2.req0_valid = 1; bus2.req0_a = 32'h3F80_0000; bus2.req0_b = 32'h4000_0000;
        #1;
        chk("t1_ready0", 32'(bus2.req0_ready), 32'd1);
        chk("t1_ready1", 32'(bus2.req1_ready), 32'd0);
        chk("t1_busy_idle", 32'(bus2.busy), 32'd0);
        tick();
        bus2.req0_valid = 0;
        chk("t1_busy", 32'(bus2.busy), 32'd1);
        chk("t1_add_a", bus2.add_a, 32'h3F80_0000);
        chk("t1_add_b", bus2.add_b, 32'h4000_0000);
        chk("t1_rv_e0", 32'(bus2.res_valid), 32'd0);
        tick();
        chk("t1_rv_e1", 32'(bus2.res_valid), 32'd0);
        chk("t1_busy_e1", 32'(bus2.busy), 32'd1);
        tick();
        chk("t1_rv_e2", 32'(bus2.res_valid), 32'd1);
        chk("t1_data", bus2.res_data, 32'h4040_0000);
        chk("t1_id", 32'(bus2.res_id), 32'd0);
        chk("t1_busy_resp", 32'(bus2.busy), 32'd1);
        bus2.res_ready = 1;
        tick();
        chk("t1_rv_done", 32'(bus2.res_valid), 32'd0);
        chk("t1_busy_done", 32'(bus2.busy), 32'd0);
        chk("t1_data_kept", bus2.res_data, 32'h4040_0000);
        bus2.res_ready = 0;

        // 2: both valid after reset, grants alternate 0,1,0,1
        rst = 1; tick(); rst = 0;
        bus2.req0_valid = 1; bus2.req0_a = 32'h3F80_0000; bus2.req0_b = 32'h3F80_0000;
        bus2.req1_valid = 1; bus2.req1_a = 32'h4040_0000; bus2.req1_b = 32'h4040_0000;
        bus2.res_ready = 1;
        #1;
        for (int k = 0; k < 4; k++) begin
            logic        g;
            logic [31:0] s;
            g = k[0];
            s = g ? 32'h40C0_0000 : 32'h4000_0000;
            chk($sformatf("t2_ready0_%0d", k), 32'(bus2.req0_ready), 32'(!g));
            chk($sformatf("t2_ready1_%0d", k), 32'(bus2.req1_ready), 32'(g));
            tick();
            chk($sformatf("t2_noready_%0d", k), 32'(bus2.req0_ready | bus2.req1_ready), 32'd0);
            tick(); tick();
            chk($sformatf("t2_rv_%0d", k), 32'(bus2.res_valid), 32'd1);
            chk($sformatf("t2_data_%0d", k), bus2.res_data, s);
            chk($sformatf("t2_id_%0d", k), 32'(bus2.res_id), 32'(g));
            tick();
            chk($sformatf("t2_idle_%0d", k), 32'(bus2.busy), 32'd0);
        end
        bus2.req0_valid = 0; bus2.req1_valid = 0; bus2.res_ready = 0;

        // 3: backpressure for 5 cycles
        bus2.req0_valid = 1; bus2.req0_a = 32'h3F80_0000; bus2.req0_b = 32'h4000_0000;
        tick();
        bus2.req0_valid = 0;
        bus2.req1_valid = 1;
        tick(); tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t3_rv_%0d", k), 32'(bus2.res_valid), 32'd1);
            chk($sformatf("t3_data_%0d", k), bus2.res_data, 32'h4040_0000);
            chk($sformatf("t3_id_%0d", k), 32'(bus2.res_id), 32'd0);
            chk($sformatf("t3_add_a_%0d", k), bus2.add_a, 32'h3F80_0000);
            chk($sformatf("t3_add_b_%0d", k), bus2.add_b, 32'h4000_0000);
            chk($sformatf("t3_ready_%0d", k), 32'(bus2.req0_ready | bus2.req1_ready), 32'd0);
            tick();
        end
        bus2.req1_valid = 0;
        bus2.res_ready = 1;
        #1;
        tick();
        chk("t3_rv_done", 32'(bus2.res_valid), 32'd0);
        chk("t3_idle", 32'(bus2.busy), 32'd0);

        // 4: req1 raised while busy waits for IDLE
        bus2.req0_valid = 1; bus2.req0_a = 32'h3F80_0000; bus2.req0_b = 32'h3F80_0000;
        tick();
        bus2.req0_valid = 0;
        bus2.req1_valid = 1; bus2.req1_a = 32'h4040_0000; bus2.req1_b = 32'h4040_0000;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t4_ready1_%0d", k), 32'(bus2.req1_ready), 32'd0);
            chk($sformatf("t4_add_a_%0d", k), bus2.add_a, 32'h3F80_0000);
            tick();
        end
        chk("t4_idle", 32'(bus2.busy), 32'd0);
        chk("t4_ready1_idle", 32'(bus2.req1_ready), 32'd1);
        tick();
        bus2.req1_valid = 0;
        chk("t4_add_a_new", bus2.add_a, 32'h4040_0000);
        chk("t4_id_new", 32'(bus2.res_id), 32'd1);
        tick(); tick();
        chk("t4_rv", 32'(bus2.res_valid), 32'd1);
        chk("t4_data", bus2.res_data, 32'h40C0_0000);
        tick();
        chk("t4_done", 32'(bus2.res_valid), 32'd0);

        // 5: reset pulse mid-BUSY discards the job
        bus2.req0_valid = 1; bus2.req0_a = 32'h1111_1111; bus2.req0_b = 32'h2222_2222;
        tick();
        bus2.req0_valid = 0;
        rst = 1;
        tick();
        chk("t5_busy", 32'(bus2.busy), 32'd0);
        chk("t5_rv", 32'(bus2.res_valid), 32'd0);
        chk("t5_add_a", bus2.add_a, 32'd0);
        chk("t5_add_b", bus2.add_b, 32'd0);
        chk("t5_ready0_rst", 32'(bus2.req0_ready), 32'd0);
        rst = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t5_no_stale_%0d", k), 32'(bus2.res_valid), 32'd0);
        end
        chk("t5_data", bus2.res_data, 32'd0);

        // 6: ADD_LAT=1, sample on first edge after accept, 3-cycle issue interval
        bus1.req0_valid = 1; bus1.req0_a = 32'h3F80_0000; bus1.req0_b = 32'h3F80_0000;
        bus1.res_ready = 1;
        #1;
        chk("t6_ready0", 32'(bus1.req0_ready), 32'd1);
        tick();
        chk("t6_busy", 32'(bus1.busy), 32'd1);
        chk("t6_rv_e0", 32'(bus1.res_valid), 32'd0);
        tick();
        chk("t6_rv_e1", 32'(bus1.res_valid), 32'd1);
        chk("t6_data", bus1.res_data, 32'h4000_0000);
        chk("t6_id", 32'(bus1.res_id), 32'd0);
        tick();
        chk("t6_rv_e2", 32'(bus1.res_valid), 32'd0);
        chk("t6_ready_again", 32'(bus1.req0_ready), 32'd1);
        tick();
        chk("t6_reaccept", 32'(bus1.busy), 32'd1);
        bus1.req0_valid = 0;
        tick(); tick();
        chk("t6_idle_end", 32'(bus1.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
